ir_direction_decoder: RTL and testbench
=======================================

Name: ir_direction_decoder

Overview:
- Front-end stage directly upstream of the visitor counter in the smart-home chain.
- Synchronises and debounces the two doorway IR sensors.
- Tracks crossing order with an FSM and emits single-cycle entry/exit pulses for the counter to increment or decrement on.
- Flags aborted, ambiguous and timed-out crossings separately so they never disturb the count.

Parameters:
- DEBOUNCE_CYCLES, 3: consecutive synchronised cycles a sensor must hold a new level before the debounced level changes (≥1).
- TIMEOUT_CYCLES, 64: maximum cycles spent in any non-IDLE crossing state before the FSM faults (≥2).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted); deassertion is synchronised externally.
- ir_sensor1  input  1  raw outer IR sensor, asynchronous, 1 = beam broken.
- ir_sensor2  input  1  raw inner IR sensor, asynchronous, 1 = beam broken.
- entry_pulse  output  1  one-cycle pulse: completed 1→2 crossing.
- exit_pulse  output  1  one-cycle pulse: completed 2→1 crossing.
- abort_pulse  output  1  one-cycle pulse: crossing abandoned, ambiguous or timed out.
- busy  output  1  high whenever FSM is not IDLE.
- sens_db  output  2  debounced sensor levels {s2,s1}, for status display.

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0; synchronisers, debounced levels and counters 0; FSM = IDLE. Mid-crossing reset discards the crossing with no pulse.
- Input path: 2-flop synchroniser per sensor, then a debounce counter.
  - Counter increments while the synchronised level ≠ debounced level, and clears on match.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES never propagate.
- Latency: raw change stable from edge 0 → sens_db changes at edge DEBOUNCE_CYCLES+2 → any resulting pulse is registered at edge DEBOUNCE_CYCLES+3 and is high for exactly one cycle.
- FSM on debounced d1/d2. States: IDLE, A1, A12, B2, B21, WAIT_CLR.
  - IDLE:
    - d1&!d2 → A1.
    - !d1&d2 → B2.
    - d1&d2 (simultaneous edge) → WAIT_CLR with abort_pulse.
  - A1:
    - d2 → A12.
    - !d1&!d2 → IDLE with abort_pulse.
  - A12:
    - !d1&!d2 → IDLE with entry_pulse.
    - Otherwise stay; the user may reverse through A12 without a pulse until both sensors clear.
    - d1&!d2 → A1 (backed out of sensor 2).
  - B2 / B21: mirror of A1 / A12.
    - B21 with !d1&!d2 → IDLE with exit_pulse.
    - B21 with !d1&d2 → B2.
  - WAIT_CLR: stays until !d1&!d2, then → IDLE with no pulse.
- Timeout: a timer clears on every state change and increments in all states except IDLE and WAIT_CLR.
  - When it reaches TIMEOUT_CYCLES, the FSM → WAIT_CLR with abort_pulse.
  - Timer width is clog2(TIMEOUT_CYCLES+1).
  - The timer saturates; it never wraps.
- Pulses are mutually exclusive; at most one of entry/exit/abort is high in any cycle.
- Back-to-back crossings need a return through IDLE; minimum spacing between two pulses is 2 cycles.

Decomposition:
- Shared package smart_home_pkg holds:
  - FSM state enum (3-bit encoding: IDLE=0, A1, A12, B2, B21, WAIT_CLR).
  - Default DEBOUNCE_CYCLES and TIMEOUT_CYCLES constants.
  - The sensor index constants.
- Sub-module ir_debounce (synchroniser + debounce counter, parameter DEBOUNCE_CYCLES, ports clk/reset/raw_in/db_out) is instantiated twice.
- The FSM, timer and pulse registers stay in ir_direction_decoder.

Test Plan:
1. Reset held 0, sensors toggling → all outputs 0 and busy=0. Release reset with sensors 0 → outputs remain 0.
2. Entry: ir1=1 for 5 cycles, then ir2=1 & ir1=0 for 5 cycles, then both 0 → exactly one entry_pulse, 6 cycles (DEBOUNCE+3) after both raw inputs clear; exit_pulse/abort_pulse stay 0.
3. Exit: reverse order 2→1→none → exactly one exit_pulse. Chain entry, entry, exit → pulse counts 2/1/0 (entry/exit/abort).
4. Glitch: ir1 high for 2 cycles (< DEBOUNCE_CYCLES=3) → sens_db stays 00, busy stays 0, no pulse.
5. Back-out: ir1=1 for 5 cycles, then 0 → one abort_pulse, no entry. Simultaneous ir1=ir2=1 from IDLE → abort_pulse, busy held until both clear.
6. Timeout: ir1 held 1 for 80 cycles → abort_pulse exactly TIMEOUT_CYCLES=64 cycles after entering A1, FSM in WAIT_CLR. Releasing ir1 → IDLE, no further pulse. Asserting reset=0 mid-A12 → no pulse, busy=0 immediately.

Source files
------------

// File: rtl/smart_home_pkg.sv
// Shared definitions for the smart-home doorway front end: direction FSM
// states, default timing constants and sensor index names.
package smart_home_pkg;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 3;
  localparam int DEFAULT_TIMEOUT_CYCLES  = 64;

  // Bit positions of each sensor inside the debounced {s2,s1} bus
  localparam int SENSOR_OUTER = 0;
  localparam int SENSOR_INNER = 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    A1       = 3'd1,
    A12      = 3'd2,
    B2       = 3'd3,
    B21      = 3'd4,
    WAIT_CLR = 3'd5
  } dir_state_e;

endpackage

// File: rtl/ir_debounce.sv
// Two-flop synchroniser followed by a debounce counter for one raw IR sensor.
// The debounced level only follows the input after it has disagreed with it
// for DEBOUNCE_CYCLES consecutive synchronised cycles.
module ir_debounce
  import smart_home_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_in,
  output logic db_out
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          meta;
  logic          sync;
  logic [CW-1:0] count;

  // Bring the asynchronous sensor into the clock domain
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= 1'b0;
      sync <= 1'b0;
    end else begin
      meta <= raw_in;
      sync <= meta;
    end
  end

  // Count consecutive disagreements; flip the level once the run is long enough
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count  <= '0;
      db_out <= 1'b0;
    end else if (sync == db_out) begin
      count <= '0;
    end else if (count == CW'(DEBOUNCE_CYCLES - 1)) begin
      count  <= '0;
      db_out <= sync;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/ir_direction_decoder.sv
// Doorway direction decoder: debounces the outer and inner IR sensors, tracks
// the order in which they are broken and emits one-cycle entry, exit or abort
// pulses. A per-state timer forces stuck crossings into WAIT_CLR.
module ir_direction_decoder
  import smart_home_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int TIMEOUT_CYCLES  = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ir_sensor1,
  input  logic       ir_sensor2,
  output logic       entry_pulse,
  output logic       exit_pulse,
  output logic       abort_pulse,
  output logic       busy,
  output logic [1:0] sens_db
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic          d1;
  logic          d2;
  dir_state_e    state;
  dir_state_e    state_next;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_next;
  logic          entry_next;
  logic          exit_next;
  logic          abort_next;
  logic          counting;

  ir_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_outer (
    .clk    (clk),
    .reset  (reset),
    .raw_in (ir_sensor1),
    .db_out (d1)
  );

  ir_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inner (
    .clk    (clk),
    .reset  (reset),
    .raw_in (ir_sensor2),
    .db_out (d2)
  );

  assign sens_db[SENSOR_OUTER] = d1;
  assign sens_db[SENSOR_INNER] = d2;
  assign busy     = (state != IDLE);
  assign counting = (state != IDLE) && (state != WAIT_CLR);

  // Crossing-order decisions, timeout override and timer update
  always_comb begin
    state_next = state;
    entry_next = 1'b0;
    exit_next  = 1'b0;
    abort_next = 1'b0;
    timer_next = timer;
    case (state)
      IDLE: begin
        if (d1 && !d2) begin
          state_next = A1;
        end else if (!d1 && d2) begin
          state_next = B2;
        end else if (d1 && d2) begin
          state_next = WAIT_CLR;
          abort_next = 1'b1;
        end
      end
      A1: begin
        if (d2) begin
          state_next = A12;
        end else if (!d1) begin
          state_next = IDLE;
          abort_next = 1'b1;
        end
      end
      A12: begin
        if (!d1 && !d2) begin
          state_next = IDLE;
          entry_next = 1'b1;
        end else if (d1 && !d2) begin
          state_next = A1;
        end
      end
      B2: begin
        if (d1) begin
          state_next = B21;
        end else if (!d2) begin
          state_next = IDLE;
          abort_next = 1'b1;
        end
      end
      B21: begin
        if (!d1 && !d2) begin
          state_next = IDLE;
          exit_next  = 1'b1;
        end else if (!d1 && d2) begin
          state_next = B2;
        end
      end
      WAIT_CLR: begin
        if (!d1 && !d2) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    // A real transition at the deadline wins; only a stalled crossing faults
    if (counting && (state_next == state) && (timer == TW'(TIMEOUT_CYCLES - 1))) begin
      state_next = WAIT_CLR;
      abort_next = 1'b1;
    end
    if (state_next != state) begin
      timer_next = '0;
    end else if (counting && (timer != TW'(TIMEOUT_CYCLES))) begin
      timer_next = timer + 1'b1;
    end
  end

  // State, timer and registered pulse outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      timer       <= '0;
      entry_pulse <= 1'b0;
      exit_pulse  <= 1'b0;
      abort_pulse <= 1'b0;
    end else begin
      state       <= state_next;
      timer       <= timer_next;
      entry_pulse <= entry_next;
      exit_pulse  <= exit_next;
      abort_pulse <= abort_next;
    end
  end

endmodule

// File: tb/tb_ir_direction_decoder.sv
// Scoreboard bench for ir_direction_decoder: a directed opening sequence then
// randomized doorway scenarios, checked against a behavioural model.
module tb_ir_direction_decoder;

  localparam int D = 3;
  localparam int T = 64;

  localparam int K_ENTRY = 1;
  localparam int K_EXIT  = 2;
  localparam int K_ABORT = 3;

  logic       clk;
  logic       reset;
  logic       ir_sensor1;
  logic       ir_sensor2;
  logic       entry_pulse;
  logic       exit_pulse;
  logic       abort_pulse;
  logic       busy;
  logic [1:0] sens_db;

  typedef struct {
    int kind;
    int cyc;
  } pulse_t;

  pulse_t expq[$];
  int     compared   = 0;
  int     mismatched = 0;
  int     cyc        = 0;
  bit     done       = 0;

  // Reference model state
  bit hist1[$];
  bit hist2[$];
  bit m_db1;
  bit m_db2;
  int phase;
  int origin;
  int since;
  int exp_db;
  bit exp_busy;

  ir_direction_decoder dut (
    .clk         (clk),
    .reset       (reset),
    .ir_sensor1  (ir_sensor1),
    .ir_sensor2  (ir_sensor2),
    .entry_pulse (entry_pulse),
    .exit_pulse  (exit_pulse),
    .abort_pulse (abort_pulse),
    .busy        (busy),
    .sens_db     (sens_db)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input int act, input int exp_v);
    compared++;
    if (act != exp_v) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic model_reset();
    hist1.delete();
    hist2.delete();
    for (int i = 0; i <= D; i++) begin
      hist1.push_back(1'b0);
      hist2.push_back(1'b0);
    end
    m_db1    = 1'b0;
    m_db2    = 1'b0;
    phase    = 0;
    origin   = 0;
    since    = cyc;
    exp_db   = 0;
    exp_busy = 1'b0;
    expq.delete();
  endtask

  // One clock edge of the model. Phases: 0 idle, 1 only the first-broken
  // sensor seen, 2 far sensor reached, 3 waiting for both to clear.
  task automatic model_step(input bit r1, input bit r2);
    bit near, far, none;
    bit all1, all2;
    int new_phase;
    int kind;
    pulse_t p;
    new_phase = phase;
    kind      = 0;
    none      = !m_db1 && !m_db2;
    near      = (origin == 1) ? m_db1 : m_db2;
    far       = (origin == 1) ? m_db2 : m_db1;
    case (phase)
      0: begin
        if (m_db1 && m_db2) begin
          new_phase = 3; kind = K_ABORT;
        end else if (m_db1 || m_db2) begin
          new_phase = 1; origin = m_db1 ? 1 : 2;
        end
      end
      1: begin
        if (far) new_phase = 2;
        else if (none) begin new_phase = 0; kind = K_ABORT; end
      end
      2: begin
        if (none) begin
          new_phase = 0; kind = (origin == 1) ? K_ENTRY : K_EXIT;
        end else if (near && !far) begin
          new_phase = 1;
        end
      end
      default: begin
        if (none) new_phase = 0;
      end
    endcase
    if ((phase == 1 || phase == 2) && new_phase == phase && (cyc - since) == T) begin
      new_phase = 3; kind = K_ABORT;
    end
    if (new_phase != phase) since = cyc;
    phase = new_phase;
    if (kind != 0) begin
      p.kind = kind; p.cyc = cyc;
      expq.push_back(p);
    end
    // Level flips once the last D synchronised samples all disagree with it
    all1 = 1'b1;
    all2 = 1'b1;
    for (int i = 0; i < D; i++) begin
      if (hist1[i] == m_db1) all1 = 1'b0;
      if (hist2[i] == m_db2) all2 = 1'b0;
    end
    if (all1) m_db1 = !m_db1;
    if (all2) m_db2 = !m_db2;
    hist1.push_back(r1); void'(hist1.pop_front());
    hist2.push_back(r2); void'(hist2.pop_front());
    exp_db   = {30'd0, m_db2, m_db1};
    exp_busy = (phase != 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (reset) model_step(ir_sensor1, ir_sensor2);
  endtask

  task automatic apply_stimulus(input bit r1, input bit r2, input int n);
    for (int i = 0; i < n; i++) begin
      ir_sensor1 = r1;
      ir_sensor2 = r2;
      tick();
    end
  endtask

  task automatic pulse_reset(input int n);
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < n; i++) tick();
    reset = 1'b1;
  endtask

  task automatic do_entry();
    apply_stimulus(1, 0, $urandom_range(4, 8));
    apply_stimulus(1, 1, $urandom_range(0, 4));
    apply_stimulus(0, 1, $urandom_range(4, 8));
    apply_stimulus(0, 0, 10);
  endtask

  task automatic do_exit();
    apply_stimulus(0, 1, $urandom_range(4, 8));
    apply_stimulus(1, 1, $urandom_range(0, 4));
    apply_stimulus(1, 0, $urandom_range(4, 8));
    apply_stimulus(0, 0, 10);
  endtask

  // Monitor: compares levels every cycle and pops the scoreboard on pulses
  initial begin
    int act_kind;
    while (!done) begin
      @(posedge clk);
      #2;
      if (done) break;
      check_output("sens_db", int'(sens_db), exp_db);
      check_output("busy", int'(busy), int'(exp_busy));
      while (expq.size() > 0 && expq[0].cyc < cyc) begin
        check_output("missed_pulse_kind", 0, expq[0].kind);
        void'(expq.pop_front());
      end
      act_kind = entry_pulse ? K_ENTRY : exit_pulse ? K_EXIT : abort_pulse ? K_ABORT : 0;
      if (act_kind != 0) begin
        check_output("pulse_exclusive", int'(entry_pulse) + int'(exit_pulse) + int'(abort_pulse), 1);
        if (expq.size() > 0 && expq[0].cyc == cyc) begin
          check_output("pulse_kind", act_kind, expq[0].kind);
          void'(expq.pop_front());
        end else begin
          check_output("unexpected_pulse", act_kind, 0);
        end
      end else if (expq.size() > 0 && expq[0].cyc == cyc) begin
        check_output("pulse_kind", 0, expq[0].kind);
        void'(expq.pop_front());
      end else begin
        check_output("no_pulse", 0, 0 + int'(entry_pulse | exit_pulse | abort_pulse));
      end
    end
  end

  // Stimulus: reset checks, directed crossings, then random scenarios
  initial begin
    reset      = 1'b0;
    ir_sensor1 = 1'b0;
    ir_sensor2 = 1'b0;
    model_reset();
    for (int i = 0; i < 8; i++) begin
      ir_sensor1 = 1'($urandom_range(0, 1));
      ir_sensor2 = 1'($urandom_range(0, 1));
      tick();
    end
    ir_sensor1 = 1'b0;
    ir_sensor2 = 1'b0;
    tick();
    reset = 1'b1;
    apply_stimulus(0, 0, 6);

    // Directed: entry with the documented 5/5 timing, exit, chain, glitch,
    // back-out, simultaneous break, timeout, reset mid-crossing
    apply_stimulus(1, 0, 5);
    apply_stimulus(0, 1, 5);
    apply_stimulus(0, 0, 10);
    do_exit();
    do_entry();
    do_entry();
    do_exit();
    apply_stimulus(1, 0, 2);
    apply_stimulus(0, 0, 8);
    apply_stimulus(1, 0, 5);
    apply_stimulus(0, 0, 8);
    apply_stimulus(1, 1, 6);
    apply_stimulus(0, 0, 8);
    apply_stimulus(1, 0, 80);
    apply_stimulus(0, 0, 8);
    apply_stimulus(1, 0, 6);
    apply_stimulus(0, 1, 6);
    pulse_reset(3);
    apply_stimulus(0, 0, 8);

    for (int s = 0; s < 60; s++) begin
      case ($urandom_range(0, 7))
        0: do_entry();
        1: do_exit();
        2: begin
          if ($urandom_range(0, 1) == 1) apply_stimulus(1, 0, $urandom_range(1, 2));
          else apply_stimulus(0, 1, $urandom_range(1, 2));
          apply_stimulus(0, 0, 8);
        end
        3: begin
          if ($urandom_range(0, 1) == 1) apply_stimulus(1, 0, $urandom_range(4, 10));
          else apply_stimulus(0, 1, $urandom_range(4, 10));
          apply_stimulus(0, 0, 8);
        end
        4: begin
          apply_stimulus(1, 1, $urandom_range(4, 10));
          apply_stimulus(0, 0, 8);
        end
        5: begin
          apply_stimulus(0, 1, $urandom_range(60, 75));
          apply_stimulus(0, 0, 8);
        end
        6: begin
          for (int i = 0; i < 24; i++)
            apply_stimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, 5));
          apply_stimulus(0, 0, 10);
        end
        default: begin
          apply_stimulus(0, 1, 6);
          apply_stimulus(1, 0, $urandom_range(1, 6));
          pulse_reset($urandom_range(1, 3));
          apply_stimulus(0, 0, 8);
        end
      endcase
    end
    apply_stimulus(0, 0, 4);
    done = 1'b1;
    @(posedge clk);
    #5;
    while (expq.size() > 0) begin
      check_output("leftover_pulse_kind", 0, expq[0].kind);
      void'(expq.pop_front());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
